// File: rtl/spio_hss_multiplexer_frame_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spio_hss_multiplexer_frame_scheduler_pkg
// Desc     : Shared defaults and state encoding for the spiNNlink transmit
//            frame scheduler and its round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package spio_hss_multiplexer_frame_scheduler_pkg;

  localparam int C_NUM_CHANS = 8;   // packet channels
  localparam int C_CRDT_BITS = 3;   // credit counter / return count width
  localparam int C_CREDITS   = 7;   // frames outstanding without ack
  localparam int C_MAX_PKTS  = 8;   // packets per frame before forced close
  localparam int C_CNT_BITS  = 4;   // packet and timeout counter width
  localparam int C_IDLE_TO   = 15;  // idle cycles in a non-empty frame before close

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CLOSE = 2'd2
  } sched_state_e;

endpackage : spio_hss_multiplexer_frame_scheduler_pkg
`default_nettype wire

// File: rtl/spio_hss_multiplexer_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spio_hss_multiplexer_rr_arbiter
// Desc     : Combinational round-robin arbiter. Picks the first eligible
//            channel at or above ptr_i, wrapping; returns one-hot and index.
// Revision : 1.0 - initial release
// ============================================================================
module spio_hss_multiplexer_rr_arbiter #(
  parameter int NUM_CHANS = 8,
  parameter int PTR_BITS  = 3
) (
  input  logic [NUM_CHANS-1:0] elig_i,
  input  logic [PTR_BITS-1:0]  ptr_i,
  output logic [NUM_CHANS-1:0] gnt_o,
  output logic [PTR_BITS-1:0]  idx_o,
  output logic                 any_o
);

  logic [PTR_BITS-1:0] w_k;

  // Scan channels starting at the pointer; first eligible one wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    w_k   = '0;
    for (int i = 0; i < NUM_CHANS; i++) begin
      w_k = PTR_BITS'((int'(ptr_i) + i) % NUM_CHANS);
      if (!any_o && elig_i[w_k]) begin
        any_o       = 1'b1;
        gnt_o[w_k]  = 1'b1;
        idx_o       = w_k;
      end
    end
  end

endmodule : spio_hss_multiplexer_rr_arbiter
`default_nettype wire

// File: rtl/spio_hss_multiplexer_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : spio_hss_multiplexer_frame_scheduler
// Desc     : spiNNlink transmit frame scheduler. Opens frames when credit is
//            available, grants channels round-robin (skipping remotely
//            stopped ones), and closes frames on full / idle timeout / stop.
// Revision : 1.0 - initial release
// ============================================================================
module spio_hss_multiplexer_frame_scheduler
  import spio_hss_multiplexer_frame_scheduler_pkg::*;
#(
  parameter int NUM_CHANS = C_NUM_CHANS,
  parameter int CRDT_BITS = C_CRDT_BITS,
  parameter int CREDITS   = C_CREDITS,
  parameter int MAX_PKTS  = C_MAX_PKTS,
  parameter int CNT_BITS  = C_CNT_BITS,
  parameter int IDLE_TO   = C_IDLE_TO
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CHANS-1:0] req_i,
  input  logic [NUM_CHANS-1:0] cfc_rem_i,
  output logic [NUM_CHANS-1:0] gnt_o,
  output logic                 gnt_vld_o,
  input  logic                 gnt_rdy_i,
  output logic                 cls_vld_o,
  input  logic                 cls_rdy_i,
  input  logic                 crdt_ret_vld_i,
  input  logic [CRDT_BITS-1:0] crdt_ret_cnt_i,
  input  logic                 reg_stop_i,
  output logic [CRDT_BITS-1:0] reg_crdt_o,
  output logic                 reg_looc_o,
  output logic                 reg_sfrm_o
);

  localparam int PW = (NUM_CHANS > 1) ? $clog2(NUM_CHANS) : 1;
  localparam logic [CRDT_BITS:0]   C_CRDT_MAX = (CRDT_BITS+1)'(CREDITS);
  localparam logic [CNT_BITS-1:0]  C_PKT_MAX  = CNT_BITS'(MAX_PKTS);
  localparam logic [CNT_BITS-1:0]  C_TO_LAST  = CNT_BITS'(IDLE_TO - 1);
  localparam logic [PW-1:0]        C_PTR_LAST = PW'(NUM_CHANS - 1);

  sched_state_e          state_q;
  logic [NUM_CHANS-1:0]  gnt_q;
  logic                  gnt_vld_q;
  logic [PW-1:0]         gnt_idx_q;
  logic [PW-1:0]         ptr_q;
  logic [CNT_BITS-1:0]   pkt_cnt_q;
  logic [CNT_BITS-1:0]   to_cnt_q;
  logic                  cls_vld_q;
  logic [CRDT_BITS-1:0]  crdt_q;
  logic [CRDT_BITS-1:0]  crdt_d;
  logic                  looc_q;
  logic                  sfrm_q;

  logic [NUM_CHANS-1:0]  w_elig;
  logic [NUM_CHANS-1:0]  w_win;
  logic [PW-1:0]         w_win_idx;
  logic                  w_any;
  logic                  w_cls_hs;
  logic [PW-1:0]         w_ptr_nxt;
  logic [CRDT_BITS:0]    w_crdt_sum;

  assign w_elig    = req_i & ~cfc_rem_i;
  assign w_cls_hs  = cls_vld_q & cls_rdy_i;
  assign w_ptr_nxt = (gnt_idx_q == C_PTR_LAST) ? '0 : gnt_idx_q + 1'b1;

  spio_hss_multiplexer_rr_arbiter #(
    .NUM_CHANS (NUM_CHANS),
    .PTR_BITS  (PW)
  ) u_arb (
    .elig_i (w_elig),
    .ptr_i  (ptr_q),
    .gnt_o  (w_win),
    .idx_o  (w_win_idx),
    .any_o  (w_any)
  );

  // Credit update: close consumes one, returns add; clamp over-return at CREDITS
  always_comb begin
    w_crdt_sum = {1'b0, crdt_q}
               + (crdt_ret_vld_i ? {1'b0, crdt_ret_cnt_i} : '0)
               - {{CRDT_BITS{1'b0}}, w_cls_hs};
    if (w_crdt_sum > C_CRDT_MAX) begin
      crdt_d = CRDT_BITS'(CREDITS);
    end else begin
      crdt_d = w_crdt_sum[CRDT_BITS-1:0];
    end
  end

  // Scheduler FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      gnt_vld_q <= 1'b0;
      gnt_idx_q <= '0;
      ptr_q     <= '0;
      pkt_cnt_q <= '0;
      to_cnt_q  <= '0;
      cls_vld_q <= 1'b0;
      crdt_q    <= CRDT_BITS'(CREDITS);
      looc_q    <= 1'b0;
      sfrm_q    <= 1'b0;
    end else begin
      crdt_q <= crdt_d;
      looc_q <= (crdt_d == '0);
      sfrm_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_any && (crdt_q != '0) && !reg_stop_i) begin
            state_q   <= ST_FILL;
            gnt_q     <= w_win;
            gnt_idx_q <= w_win_idx;
            gnt_vld_q <= 1'b1;
            to_cnt_q  <= '0;
          end
        end
        ST_FILL: begin
          if (gnt_vld_q) begin
            // Grant held until consumed; the following bubble lets req settle
            if (gnt_rdy_i) begin
              gnt_vld_q <= 1'b0;
              gnt_q     <= '0;
              pkt_cnt_q <= pkt_cnt_q + 1'b1;
              to_cnt_q  <= '0;
              ptr_q     <= w_ptr_nxt;
            end
          end else if (pkt_cnt_q == C_PKT_MAX || reg_stop_i) begin
            state_q   <= ST_CLOSE;
            cls_vld_q <= 1'b1;
          end else if (w_any) begin
            gnt_q     <= w_win;
            gnt_idx_q <= w_win_idx;
            gnt_vld_q <= 1'b1;
          end else if (to_cnt_q == C_TO_LAST) begin
            state_q   <= ST_CLOSE;
            cls_vld_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        ST_CLOSE: begin
          if (cls_rdy_i) begin
            state_q   <= ST_IDLE;
            cls_vld_q <= 1'b0;
            pkt_cnt_q <= '0;
            to_cnt_q  <= '0;
            sfrm_q    <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt_o      = gnt_q;
  assign gnt_vld_o  = gnt_vld_q;
  assign cls_vld_o  = cls_vld_q;
  assign reg_crdt_o = crdt_q;
  assign reg_looc_o = looc_q;
  assign reg_sfrm_o = sfrm_q;

endmodule : spio_hss_multiplexer_frame_scheduler
`default_nettype wire

// File: tb/tb_spio_hss_multiplexer_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_spio_hss_multiplexer_frame_scheduler
// Desc     : Directed bench for the frame scheduler. Expected grants are
//            queued as stimulus is issued and popped by a grant monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spio_hss_multiplexer_frame_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] cfc_rem;
  logic [7:0] gnt;
  logic       gnt_vld;
  logic       gnt_rdy;
  logic       cls_vld;
  logic       cls_rdy;
  logic       crdt_ret_vld;
  logic [2:0] crdt_ret_cnt;
  logic       reg_stop;
  logic [2:0] reg_crdt;
  logic       reg_looc;
  logic       reg_sfrm;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  spio_hss_multiplexer_frame_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req),
    .cfc_rem_i      (cfc_rem),
    .gnt_o          (gnt),
    .gnt_vld_o      (gnt_vld),
    .gnt_rdy_i      (gnt_rdy),
    .cls_vld_o      (cls_vld),
    .cls_rdy_i      (cls_rdy),
    .crdt_ret_vld_i (crdt_ret_vld),
    .crdt_ret_cnt_i (crdt_ret_cnt),
    .reg_stop_i     (reg_stop),
    .reg_crdt_o     (reg_crdt),
    .reg_looc_o     (reg_looc),
    .reg_sfrm_o     (reg_sfrm)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Grant monitor: every accepted grant must match the next queued expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && gnt_vld === 1'b1 && gnt_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_grant act=%0h exp=none @%0t", gnt, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("grant_order", 32'(gnt), 32'(mon_exp));
      end
    end
  end

  task automatic do_reset;
    rst_n        = 1'b0;
    req          = '0;
    cfc_rem      = '0;
    gnt_rdy      = 1'b0;
    cls_rdy      = 1'b0;
    crdt_ret_vld = 1'b0;
    crdt_ret_cnt = '0;
    reg_stop     = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic wait_cls(input string name);
    int n;
    n = 0;
    while (cls_vld !== 1'b1 && n < 30) begin
      tick;
      n++;
    end
    chk(name, 32'(cls_vld), 32'h1);
  endtask

  // One-packet frame on channel ch, closed by stop; cls_rdy left low
  task automatic open_stop(input int ch);
    exp_q.push_back(8'(1 << ch));
    req      = 8'(1 << ch);
    gnt_rdy  = 1'b1;
    reg_stop = 1'b0;
    cls_rdy  = 1'b0;
    tick;
    req      = '0;
    reg_stop = 1'b1;
    wait_cls("stop_close");
  endtask

  task automatic close_frame;
    cls_rdy = 1'b1;
    tick;
    chk("sfrm_pulse", 32'(reg_sfrm), 32'h1);
    cls_rdy  = 1'b0;
    reg_stop = 1'b0;
  endtask

  task automatic do_frame(input int ch);
    open_stop(ch);
    close_frame;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic seen;

    // ---- reset state
    do_reset;
    chk("rst_gnt_vld", 32'(gnt_vld), 32'h0);
    chk("rst_cls_vld", 32'(cls_vld), 32'h0);
    chk("rst_crdt",    32'(reg_crdt), 32'h7);
    chk("rst_looc",    32'(reg_looc), 32'h0);
    chk("rst_sfrm",    32'(reg_sfrm), 32'h0);

    // ---- single packet, idle-timeout close
    exp_q.push_back(8'h01);
    req     = 8'h01;
    gnt_rdy = 1'b1;
    tick;
    chk("first_gnt_vld", 32'(gnt_vld), 32'h1);
    chk("first_gnt",     32'(gnt),     32'h01);
    req = '0;
    tick;
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick;
      seen = seen | cls_vld;
    end
    chk("timeout_not_early", 32'(seen), 32'h0);
    tick;
    chk("timeout_close", 32'(cls_vld), 32'h1);
    cls_rdy = 1'b1;
    tick;
    chk("t1_crdt",     32'(reg_crdt), 32'h6);
    chk("t1_sfrm",     32'(reg_sfrm), 32'h1);
    chk("t1_cls_drop", 32'(cls_vld),  32'h0);
    cls_rdy = 1'b0;
    tick;
    chk("t1_sfrm_once", 32'(reg_sfrm), 32'h0);

    // ---- round robin with remote flow control, close at MAX_PKTS
    do_reset;
    exp_q.push_back(8'h01); exp_q.push_back(8'h04);
    exp_q.push_back(8'h10); exp_q.push_back(8'h20);
    exp_q.push_back(8'h40); exp_q.push_back(8'h80);
    exp_q.push_back(8'h01); exp_q.push_back(8'h04);
    req     = 8'hFF;
    cfc_rem = 8'h0A;
    gnt_rdy = 1'b1;
    n = 0;
    while (cls_vld !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    chk("full_close_cycle", 32'(n), 32'd17);
    chk("rr_all_granted", 32'(exp_q.size()), 32'h0);
    req     = '0;
    cls_rdy = 1'b1;
    tick;
    chk("t2_crdt", 32'(reg_crdt), 32'h6);
    cls_rdy = 1'b0;
    cfc_rem = '0;

    // ---- grant hold while request withdrawn / channel stopped
    do_reset;
    exp_q.push_back(8'h04);
    req     = 8'h04;
    gnt_rdy = 1'b0;
    tick;
    req     = '0;
    cfc_rem = 8'h04;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("hold_gnt",     32'(gnt),     32'h04);
      chk("hold_gnt_vld", 32'(gnt_vld), 32'h1);
    end
    gnt_rdy = 1'b1;
    tick;
    chk("hold_released", 32'(gnt_vld), 32'h0);
    cfc_rem = '0;

    // ---- credit exhaustion and recovery
    do_reset;
    for (int f = 0; f < 7; f++) do_frame(f);
    chk("exh_crdt", 32'(reg_crdt), 32'h0);
    chk("exh_looc", 32'(reg_looc), 32'h1);
    req     = 8'h01;
    gnt_rdy = 1'b1;
    seen    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      seen = seen | gnt_vld;
    end
    chk("exh_no_grant", 32'(seen), 32'h0);
    exp_q.push_back(8'h01);
    crdt_ret_vld = 1'b1;
    crdt_ret_cnt = 3'd2;
    tick;
    crdt_ret_vld = 1'b0;
    crdt_ret_cnt = '0;
    chk("ret_crdt", 32'(reg_crdt), 32'h2);
    chk("ret_looc", 32'(reg_looc), 32'h0);
    tick;
    chk("resume_gnt_vld", 32'(gnt_vld), 32'h1);
    req      = '0;
    reg_stop = 1'b1;
    wait_cls("resume_close");
    close_frame;
    chk("resume_crdt", 32'(reg_crdt), 32'h1);

    // ---- simultaneous close and return
    do_reset;
    for (int f = 0; f < 4; f++) do_frame(f);
    chk("pre_sim_crdt", 32'(reg_crdt), 32'h3);
    open_stop(4);
    cls_rdy      = 1'b1;
    crdt_ret_vld = 1'b1;
    crdt_ret_cnt = 3'd1;
    tick;
    chk("sim_crdt", 32'(reg_crdt), 32'h3);
    chk("sim_sfrm", 32'(reg_sfrm), 32'h1);
    cls_rdy      = 1'b0;
    crdt_ret_vld = 1'b0;
    crdt_ret_cnt = '0;
    reg_stop     = 1'b0;

    // ---- saturation
    do_reset;
    crdt_ret_vld = 1'b1;
    crdt_ret_cnt = 3'd3;
    tick;
    crdt_ret_vld = 1'b0;
    chk("sat_full", 32'(reg_crdt), 32'h7);
    do_frame(5);
    chk("sat_pre", 32'(reg_crdt), 32'h6);
    crdt_ret_vld = 1'b1;
    crdt_ret_cnt = 3'd3;
    tick;
    crdt_ret_vld = 1'b0;
    crdt_ret_cnt = '0;
    chk("sat_clamp", 32'(reg_crdt), 32'h7);
    chk("sat_looc",  32'(reg_looc), 32'h0);

    // ---- stop mid-frame, then async reset during CLOSE
    do_reset;
    do_frame(0);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h01);
    req     = 8'h01;
    gnt_rdy = 1'b1;
    for (int i = 0; i < 7; i++) tick;
    chk("stop_pending_vld", 32'(gnt_vld), 32'h1);
    gnt_rdy  = 1'b0;
    req      = '0;
    reg_stop = 1'b1;
    tick;
    tick;
    chk("stop_hold_vld", 32'(gnt_vld), 32'h1);
    chk("stop_no_close", 32'(cls_vld), 32'h0);
    gnt_rdy = 1'b1;
    tick;
    chk("stop_hs_done", 32'(gnt_vld), 32'h0);
    chk("stop_bubble",  32'(cls_vld), 32'h0);
    tick;
    chk("stop_close", 32'(cls_vld), 32'h1);
    chk("stop_crdt",  32'(reg_crdt), 32'h6);
    rst_n = 1'b0;
    #1;
    chk("arst_cls_vld", 32'(cls_vld),  32'h0);
    chk("arst_crdt",    32'(reg_crdt), 32'h7);
    chk("arst_gnt_vld", 32'(gnt_vld),  32'h0);
    reg_stop = 1'b0;
    gnt_rdy  = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_spio_hss_multiplexer_frame_scheduler
`default_nettype wire
